// File: rtl/seg_scan_if.sv
// Bundle of write/control inputs and registered display outputs for seg_scan_ctrl.
// master = data source / decoder side, slave = the scan controller.
interface seg_scan_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       hold;
  logic [7:0] digit_en;
  logic       a, b, c, d;
  logic       s1, s2, s3;
  logic       blank;
  logic       tick;

  modport master (
    output wr_en, wr_addr, wr_data, hold, digit_en,
    input  a, b, c, d, s1, s2, s3, blank, tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, hold, digit_en,
    output a, b, c, d, s1, s2, s3, blank, tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit time-multiplexed seven-segment scan controller.
// Define SEG_SCAN_LZ_BLANK_EN to add leading-zero suppression to the blank flag.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] TC = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       idx_p0;
  logic [3:0]       digit_p0 [8];

  logic [3:0]       val_p1;
  logic [2:0]       sel_p1;
  logic             blank_p1;
  logic             tick_p1;

  logic             adv;
  logic [2:0]       idx_nxt;
  logic [3:0]       digit_nxt [8];
  logic             blank_nxt;

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Bit i set when digit i and every digit above it are zero; digit 0 always shows.
  function automatic logic [7:0] lz_mask(input logic [31:0] dig);
    logic [7:0] m;
    logic       zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above = zero_above & (dig[4*i +: 4] == 4'h0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  logic [31:0] dig_flat;
  logic [7:0]  lz;

  always_comb begin
    dig_flat = '0;
    for (int i = 0; i < 8; i++) dig_flat[4*i +: 4] = digit_nxt[i];
  end

  assign lz        = lz_mask(dig_flat);
  assign blank_nxt = ~bus.digit_en[idx_nxt] | lz[idx_nxt];
`else
  assign blank_nxt = ~bus.digit_en[idx_nxt];
`endif

  assign adv     = (cnt_p0 == TC) && !bus.hold;
  assign idx_nxt = adv ? idx_p0 + 3'd1 : idx_p0;

  // Outputs are built from next-state values so index, value and tick stay in the same cycle.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      digit_nxt[i] = (bus.wr_en && (bus.wr_addr == 3'(i))) ? bus.wr_data : digit_p0[i];
    end
  end

  // Stage p0: prescaler, index and digit storage; stage p1: registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0   <= '0;
      idx_p0   <= '0;
      for (int i = 0; i < 8; i++) digit_p0[i] <= '0;
      val_p1   <= '0;
      sel_p1   <= '0;
      blank_p1 <= 1'b0;
      tick_p1  <= 1'b0;
    end else begin
      if (!bus.hold) cnt_p0 <= adv ? '0 : cnt_p0 + CNT_W'(1);
      idx_p0   <= idx_nxt;
      for (int i = 0; i < 8; i++) digit_p0[i] <= digit_nxt[i];
      val_p1   <= digit_nxt[idx_nxt];
      sel_p1   <= idx_nxt;
      blank_p1 <= blank_nxt;
      tick_p1  <= adv;
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d} = val_p1;
  assign {bus.s1, bus.s2, bus.s3}     = sel_p1;
  assign bus.blank                    = blank_p1;
  assign bus.tick                     = tick_p1;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a cycle-level reference model feeding an expected-output queue.
module tb_seg_scan_ctrl;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q [$];
  logic [8:0] obs;

  int         m_cnt;
  logic [2:0] m_idx;
  logic [3:0] m_dig [8];

  function automatic logic [8:0] pack_obs();
    return {bus.tick, bus.blank, bus.s1, bus.s2, bus.s3, bus.a, bus.b, bus.c, bus.d};
  endfunction

  function automatic logic m_lz(input logic [2:0] idx);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (idx == 3'd0) return 1'b0;
    for (int j = int'(idx); j < 8; j++) if (m_dig[j] != 4'h0) return 1'b0;
    return 1'b1;
`else
    return (idx == 3'd0) && (idx != 3'd0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 3'd0;
    for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
  endtask

  // One clock: predict from the inputs about to be sampled, then compare after the edge.
  task automatic step();
    logic       adv;
    logic [8:0] e;
    adv = (m_cnt == DIV - 1) && !bus.hold;
    if (bus.wr_en) m_dig[bus.wr_addr] = bus.wr_data;
    if (!bus.hold) m_cnt = adv ? 0 : m_cnt + 1;
    if (adv) m_idx = m_idx + 3'd1;
    e = {adv, ~bus.digit_en[m_idx] | m_lz(m_idx), m_idx, m_dig[m_idx]};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs = pack_obs();
    chk("cycle", {23'd0, obs}, {23'd0, exp_q.pop_front()});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until index t has just appeared; expired budget counts as a failure.
  task automatic run_to_idx(input logic [2:0] t);
    int budget;
    budget = 200;
    do begin
      step();
      budget--;
    end while (!(m_idx == t && m_cnt == 0 && obs[8]) && budget > 0);
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL run_to_idx observed=timeout expected=index %0d", t);
    end
  endtask

  task automatic write_digit(input logic [2:0] addr, input logic [3:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    logic [2:0] s0;
    logic [7:0] lz_exp;

    bus.wr_en    = 1'b0;
    bus.wr_addr  = 3'd0;
    bus.wr_data  = 4'h0;
    bus.hold     = 1'b0;
    bus.digit_en = 8'hFF;
    rst          = 1'b1;
    model_reset();
    #12;
    chk("reset_outputs", {23'd0, pack_obs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Scan and wrap with digits 1..8
    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(i + 1));
    run_to_idx(3'd0);
    for (int k = 1; k <= 8; k++) begin
      run(DIV - 1);
      chk("scan_notick", {31'd0, obs[8]}, 32'd0);
      step();
      chk("scan_tick", {23'd0, obs}, {23'd0, 1'b1, 1'b0, 3'(k % 8), 4'((k % 8) + 1)});
    end

    // Asynchronous reset at index 5
    run_to_idx(3'd5);
    step();
    #3 rst = 1'b1;
    #1;
    chk("async_reset", {23'd0, pack_obs()}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k < DIV; k++) begin
      step();
      chk("post_reset_notick", {31'd0, obs[8]}, 32'd0);
    end
    step();
    chk("post_reset_tick", {28'd0, obs[8], obs[6:4]}, {28'd0, 1'b1, 3'd1});

    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(i + 1));

    // Write to the digit currently shown
    run_to_idx(3'd3);
    write_digit(3'd3, 4'hA);
    chk("live_write", {25'd0, obs[6:0]}, {25'd0, 3'd3, 4'hA});

    // Hold across the terminal count
    run(DIV - 1 - m_cnt);
    s0 = m_idx;
    bus.hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_frozen", {28'd0, obs[8], obs[6:4]}, {28'd0, 1'b0, s0});
    end
    bus.hold = 1'b0;
    step();
    chk("hold_release", {28'd0, obs[8], obs[6:4]}, {28'd0, 1'b1, s0 + 3'd1});

    // Blank mask 0x0F
    bus.digit_en = 8'h0F;
    run_to_idx(3'd0);
    for (int k = 0; k < 8 * DIV; k++) begin
      step();
      chk("mask_blank", {31'd0, obs[7]}, {31'd0, obs[6:4] >= 3'd4});
    end

    // Leading-zero pattern: digits 7..0 = 0,0,0,0,0,3,0,7
    bus.digit_en = 8'hFF;
    for (int i = 0; i < 8; i++) write_digit(3'(i), (i == 0) ? 4'h7 : (i == 2) ? 4'h3 : 4'h0);
`ifdef SEG_SCAN_LZ_BLANK_EN
    lz_exp = 8'b1111_1000;
`else
    lz_exp = 8'b0000_0000;
`endif
    for (int k = 0; k < 8 * DIV; k++) begin
      step();
      chk("lz_blank", {31'd0, obs[7]}, {31'd0, lz_exp[obs[6:4]]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
